alu_exec_stage: RTL and testbench

Two-entry pipelined execute stage that owns the 32-bit ALU. It accepts operations from decode over a valid/ready handshake, translates ALUOp/funct into the ALU's Binvert/Carryin/Operation controls, and drives the operands. It captures Result/CarryOut/Zero plus derived overflow and set-less-than, and presents them downstream with backpressure.

---
 rtl/alu_exec_pkg.sv | 26 ++
 rtl/alu_ctrl_decode.sv | 66 ++++++
 rtl/alu_exec_stage.sv | 143 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute stage: ALUOp values, R-type funct codes,
// ALU operation selects and the result-kind enum.
package alu_exec_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUM = 2'b10;

    typedef enum logic [1:0] {
        K_LOGIC = 2'b00,
        K_ARITH = 2'b01,
        K_SLT   = 2'b10,
        K_ILL   = 2'b11
    } kind_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps ALUOp/funct onto ALU Binvert/Carryin/Operation controls and a result kind.
// Optional macro ALU_SLT_EN makes funct 101010 (set-less-than) legal.
module alu_ctrl_decode
    import alu_exec_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic       o_binvert,
    output logic       o_carryin,
    output logic [1:0] o_operation,
    output logic [1:0] o_kind
);

    always_comb begin
        // Anything not matched below is illegal and runs as a harmless AND.
        o_binvert   = 1'b0;
        o_carryin   = 1'b0;
        o_operation = OP_AND;
        o_kind      = K_ILL;
        case (i_alu_op)
            ALUOP_ADD: begin
                o_operation = OP_SUM;
                o_kind      = K_ARITH;
            end
            ALUOP_SUB: begin
                o_operation = OP_SUM;
                o_binvert   = 1'b1;
                o_carryin   = 1'b1;
                o_kind      = K_ARITH;
            end
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: begin
                        o_operation = OP_SUM;
                        o_kind      = K_ARITH;
                    end
                    FUNCT_SUB: begin
                        o_operation = OP_SUM;
                        o_binvert   = 1'b1;
                        o_carryin   = 1'b1;
                        o_kind      = K_ARITH;
                    end
                    FUNCT_AND: begin
                        o_operation = OP_AND;
                        o_kind      = K_LOGIC;
                    end
                    FUNCT_OR: begin
                        o_operation = OP_OR;
                        o_kind      = K_LOGIC;
                    end
`ifdef ALU_SLT_EN
                    FUNCT_SLT: begin
                        o_operation = OP_SUM;
                        o_binvert   = 1'b1;
                        o_carryin   = 1'b1;
                        o_kind      = K_SLT;
                    end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-entry execute stage around an external 32-bit ALU: S1 drives the ALU,
// S2 holds the finished result for downstream. SLT support follows ALU_SLT_EN.
module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [1:0]       i_in_alu_op,
    input  logic [5:0]       i_in_funct,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic             o_alu_binvert,
    output logic             o_alu_carryin,
    output logic [1:0]       o_alu_operation,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_carryout,
    input  logic             i_alu_zero,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_result,
    output logic             o_out_carry,
    output logic             o_out_zero,
    output logic             o_out_overflow,
    output logic             o_out_illegal
);

    logic             w_binvert, w_carryin;
    logic [1:0]       w_operation, w_kind;
    logic             w_s2_free, w_s1_adv, w_accept, w_ovf, w_slt_bit;
    logic [WIDTH-1:0] w_fin_result;
    logic             w_fin_carry, w_fin_zero, w_fin_ovf, w_fin_ill;

    logic             r_s1_valid, r_s1_binv, r_s1_cin;
    logic [1:0]       r_s1_op, r_s1_kind;
    logic [WIDTH-1:0] r_s1_a, r_s1_b;
    logic             r_s2_valid, r_s2_carry, r_s2_zero, r_s2_ovf, r_s2_ill;
    logic [WIDTH-1:0] r_s2_result;

    alu_ctrl_decode u_decode (
        .i_alu_op    (i_in_alu_op),
        .i_funct     (i_in_funct),
        .o_binvert   (w_binvert),
        .o_carryin   (w_carryin),
        .o_operation (w_operation),
        .o_kind      (w_kind)
    );

    assign w_s2_free  = !r_s2_valid || i_out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign o_in_ready = !r_s1_valid || w_s2_free;
    assign w_accept   = i_in_valid && o_in_ready;

    // Signed overflow of a + (b ^ binv): operands agree in sign, result does not.
    assign w_ovf = (r_s1_a[WIDTH-1] == (r_s1_b[WIDTH-1] ^ r_s1_binv)) &&
                   (i_alu_result[WIDTH-1] != r_s1_a[WIDTH-1]);
    assign w_slt_bit = i_alu_result[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_fin_result = '0;
        w_fin_carry  = 1'b0;
        w_fin_zero   = i_alu_zero;
        w_fin_ovf    = 1'b0;
        w_fin_ill    = 1'b0;
        case (r_s1_kind)
            K_ARITH: begin
                w_fin_result = i_alu_result;
                w_fin_carry  = i_alu_carryout;
                w_fin_ovf    = w_ovf;
            end
            K_LOGIC: w_fin_result = i_alu_result;
            K_SLT: begin
                w_fin_result = {{(WIDTH-1){1'b0}}, w_slt_bit};
                w_fin_zero   = !w_slt_bit;
            end
            default: begin
                w_fin_ill  = 1'b1;
                w_fin_zero = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_binv  <= 1'b0;
            r_s1_cin   <= 1'b0;
            r_s1_op    <= OP_AND;
            r_s1_kind  <= K_LOGIC;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_binv  <= w_binvert;
            r_s1_cin   <= w_carryin;
            r_s1_op    <= w_operation;
            r_s1_kind  <= w_kind;
            r_s1_a     <= i_in_a;
            r_s1_b     <= i_in_b;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_carry  <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_ovf    <= 1'b0;
            r_s2_ill    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid  <= 1'b1;
            r_s2_result <= w_fin_result;
            r_s2_carry  <= w_fin_carry;
            r_s2_zero   <= w_fin_zero;
            r_s2_ovf    <= w_fin_ovf;
            r_s2_ill    <= w_fin_ill;
        end else if (i_out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign o_alu_a         = r_s1_a;
    assign o_alu_b         = r_s1_b;
    assign o_alu_binvert   = r_s1_binv;
    assign o_alu_carryin   = r_s1_cin;
    assign o_alu_operation = r_s1_op;

    assign o_out_valid    = r_s2_valid;
    assign o_out_result   = r_s2_result;
    assign o_out_carry    = r_s2_carry;
    assign o_out_zero     = r_s2_zero;
    assign o_out_overflow = r_s2_ovf;
    assign o_out_illegal  = r_s2_ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: behavioural ALU beside the DUT, scoreboard of
// arithmetic-level expected results, directed plan cases plus random traffic.
module tb_alu_exec_stage;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_in_valid, o_in_ready;
    logic [1:0]  i_in_alu_op;
    logic [5:0]  i_in_funct;
    logic [31:0] i_in_a, i_in_b;
    logic [31:0] o_alu_a, o_alu_b;
    logic        o_alu_binvert, o_alu_carryin;
    logic [1:0]  o_alu_operation;
    logic [31:0] i_alu_result;
    logic        i_alu_carryout, i_alu_zero;
    logic        o_out_valid, i_out_ready;
    logic [31:0] o_out_result;
    logic        o_out_carry, o_out_zero, o_out_overflow, o_out_illegal;

    always #5 i_clk = ~i_clk;

    alu_exec_stage #(.WIDTH(32)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_in_valid      (i_in_valid),
        .o_in_ready      (o_in_ready),
        .i_in_alu_op     (i_in_alu_op),
        .i_in_funct      (i_in_funct),
        .i_in_a          (i_in_a),
        .i_in_b          (i_in_b),
        .o_alu_a         (o_alu_a),
        .o_alu_b         (o_alu_b),
        .o_alu_binvert   (o_alu_binvert),
        .o_alu_carryin   (o_alu_carryin),
        .o_alu_operation (o_alu_operation),
        .i_alu_result    (i_alu_result),
        .i_alu_carryout  (i_alu_carryout),
        .i_alu_zero      (i_alu_zero),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_out_result    (o_out_result),
        .o_out_carry     (o_out_carry),
        .o_out_zero      (o_out_zero),
        .o_out_overflow  (o_out_overflow),
        .o_out_illegal   (o_out_illegal)
    );

    // The ALU that sits beside the stage in the real datapath.
    logic [31:0] w_bb;
    logic [32:0] w_sum;
    always_comb begin
        w_bb  = o_alu_binvert ? ~o_alu_b : o_alu_b;
        w_sum = {1'b0, o_alu_a} + {1'b0, w_bb} + {32'b0, o_alu_carryin};
        case (o_alu_operation)
            2'b00:   i_alu_result = o_alu_a & w_bb;
            2'b01:   i_alu_result = o_alu_a | w_bb;
            default: i_alu_result = w_sum[31:0];
        endcase
        i_alu_carryout = w_sum[32];
        i_alu_zero     = (i_alu_result == 32'h0);
    end

    typedef struct packed {
        logic [31:0] res;
        logic        carry;
        logic        zero;
        logic        ovf;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          kind;  // 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 illegal
        longint      sa, sb, s;
        logic [63:0] u;
        kind = 5;
        if (op == 2'b00) kind = 0;
        else if (op == 2'b01) kind = 1;
        else if (op == 2'b10) begin
            case (f)
                6'h20:   kind = 0;
                6'h22:   kind = 1;
                6'h24:   kind = 2;
                6'h25:   kind = 3;
`ifdef ALU_SLT_EN
                6'h2a:   kind = 4;
`endif
                default: kind = 5;
            endcase
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (kind)
            0: begin
                u       = {32'b0, a} + {32'b0, b};
                s       = sa + sb;
                e.res   = a + b;
                e.carry = u[32];
                e.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            1: begin
                s       = sa - sb;
                e.res   = a - b;
                e.carry = (a >= b);
                e.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    // Scoreboard and hold-stability monitor.
    logic [36:0] snap;
    logic        held = 1'b0;
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            if (held)
                check("hold", {o_out_valid, o_out_result, o_out_carry, o_out_zero,
                               o_out_overflow, o_out_illegal}, {27'b0, snap});
            if (o_out_valid && i_out_ready) begin
                if (q.size() == 0) check("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    check("res", o_out_result, e.res);
                    check("flags", {o_out_carry, o_out_zero, o_out_overflow, o_out_illegal},
                          {e.carry, e.zero, e.ovf, e.ill});
                end
            end
            if (i_in_valid && o_in_ready) q.push_back(model(i_in_alu_op, i_in_funct, i_in_a, i_in_b));
            held = o_out_valid && !i_out_ready;
            snap = {o_out_valid, o_out_result, o_out_carry, o_out_zero, o_out_overflow,
                    o_out_illegal};
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h7fffffff;
            2:       return 32'h80000000;
            3:       return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_op();
        logic [5:0] fl[6];
        int         r, idx;
        fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        r  = $urandom_range(0, 9);
        i_in_alu_op = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        idx = $urandom_range(0, 6);
        i_in_funct = (idx == 6) ? 6'($urandom) : fl[idx];
        i_in_a = pick_operand();
        i_in_b = ($urandom_range(0, 7) == 0) ? i_in_a : pick_operand();
    endtask

    // Offer one op and hold it until accepted; called just after a rising edge.
    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok          = 1'b0;
        i_in_valid  = 1'b1;
        i_in_alu_op = op;
        i_in_funct  = f;
        i_in_a      = a;
        i_in_b      = b;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_in_ready) ok = 1'b1;
            @(posedge i_clk);
            #1;
            if (ok) break;
        end
        i_in_valid = 1'b0;
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        logic tk;
        i_rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b1;
        i_in_alu_op = 2'b00; i_in_funct = 6'h0; i_in_a = '0; i_in_b = '0;
        idle(2);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_in_ready", o_in_ready, 1);
        check("rst_alu_ctrl", {o_alu_operation, o_alu_binvert, o_alu_carryin}, 0);
        check("rst_alu_ops", {o_alu_a, o_alu_b}, 0);
        check("rst_outputs", {o_out_result, o_out_carry, o_out_zero, o_out_overflow,
                              o_out_illegal}, 0);
        @(posedge i_clk);
        #1;

        // Latency: accepted at edge N, visible after edge N+1.
        i_in_valid = 1'b1; i_in_alu_op = 2'b00; i_in_a = 32'ha5a5a5a5; i_in_b = 32'h5a5a5a5a;
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        @(negedge i_clk);
        check("lat_n", o_out_valid, 0);
        @(negedge i_clk);
        check("lat_n1", o_out_valid, 1);
        @(posedge i_clk);
        #1;

        send(2'b00, 6'h00, 32'h7fffffff, 32'h00000001);
        send(2'b01, 6'h00, 32'h12345678, 32'h12345678);
        send(2'b10, 6'h24, 32'ha5a5a5a5, 32'h5a5a5a5a);
        send(2'b10, 6'h25, 32'ha5a5a5a5, 32'h5a5a5a5a);
        send(2'b10, 6'h2a, 32'hffffffff, 32'h00000001);
        send(2'b10, 6'h2a, 32'h00000001, 32'hffffffff);
        send(2'b10, 6'h00, 32'h12345678, 32'h9abcdef0);
        send(2'b11, 6'h20, 32'h1, 32'h2);
        send(2'b10, 6'h22, 32'h00000000, 32'h00000001);
        idle(4);

        // Backpressure: only two ops fit while downstream stalls.
        i_out_ready = 1'b0;
        rand_op();
        i_in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            tk = o_in_ready;
            if (tk) acc++;
            @(posedge i_clk);
            #1;
            if (tk) rand_op();
        end
        check("bp_accepts", acc, 2);
        @(negedge i_clk);
        check("bp_in_ready", o_in_ready, 0);
        check("bp_out_valid", o_out_valid, 1);
        @(posedge i_clk);
        #1;
        i_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            check("bp_stream", o_out_valid, 1);
            tk = i_in_valid && o_in_ready;
            @(posedge i_clk);
            #1;
            if (tk) begin
                acc++;
                if (acc < 4) rand_op();
                else i_in_valid = 1'b0;
            end
        end
        check("bp_total", acc, 4);
        idle(3);

        // Random traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            @(negedge i_clk);
            tk = i_in_valid && o_in_ready;
            @(posedge i_clk);
            #1;
            if (!i_in_valid || tk) begin
                i_in_valid = ($urandom_range(0, 3) != 0);
                rand_op();
            end
            i_out_ready = ($urandom_range(0, 3) != 0);
        end

        // Reset with ops in flight discards them.
        i_out_ready = 1'b0;
        i_in_valid  = 1'b1;
        rand_op();
        idle(3);
        i_rst      = 1'b1;
        i_in_valid = 1'b0;
        idle(2);
        i_rst       = 1'b0;
        i_out_ready = 1'b1;
        @(negedge i_clk);
        check("mrst_out_valid", o_out_valid, 0);
        check("mrst_in_ready", o_in_ready, 1);
        check("mrst_alu_op", o_alu_operation, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            check("mrst_no_stale", o_out_valid, 0);
        end
        @(posedge i_clk);
        #1;
        send(2'b00, 6'h00, 32'h00000005, 32'h00000007);
        idle(5);
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
